// File: rtl/axi_dma_cmd_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ DMA command channels into one controller port
// and routes each in-order completion back to the requester that issued it.
module axi_dma_cmd_arbiter #(
    parameter  int NUM_REQ         = 4,
    parameter  int ADDR_WD         = 32,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int ID_WD           = $clog2(NUM_REQ),
    localparam int CNT_WD          = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*ADDR_WD-1:0] req_src_addr,
    input  logic [NUM_REQ*ADDR_WD-1:0] req_dst_addr,
    input  logic [NUM_REQ*2-1:0]       req_burst,
    input  logic [NUM_REQ*ADDR_WD-1:0] req_len,
    input  logic [NUM_REQ*3-1:0]       req_size,
    output logic [NUM_REQ-1:0]         req_done,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic [ADDR_WD-1:0]         cmd_src_addr,
    output logic [ADDR_WD-1:0]         cmd_dst_addr,
    output logic [1:0]                 cmd_burst,
    output logic [ADDR_WD-1:0]         cmd_len,
    output logic [2:0]                 cmd_size,
    output logic [ID_WD-1:0]           cmd_id,
    input  logic                       dma_done,
    output logic [CNT_WD-1:0]          outstanding,
    output logic                       err_done
);
    localparam int PTR_WD = $clog2(MAX_OUTSTANDING);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t              state_reg, state_next;
    logic [ID_WD-1:0]    last_grant_reg;
    logic [ID_WD-1:0]    winner, cand;
    logic                found, grant, push, pop;

    logic [ADDR_WD-1:0]  src_arr   [NUM_REQ];
    logic [ADDR_WD-1:0]  dst_arr   [NUM_REQ];
    logic [ADDR_WD-1:0]  len_arr   [NUM_REQ];
    logic [1:0]          burst_arr [NUM_REQ];
    logic [2:0]          size_arr  [NUM_REQ];

    logic [ID_WD-1:0]    id_mem_reg [MAX_OUTSTANDING];
    logic [PTR_WD-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_WD-1:0]   count_reg;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign src_arr[gi]   = req_src_addr[gi*ADDR_WD +: ADDR_WD];
            assign dst_arr[gi]   = req_dst_addr[gi*ADDR_WD +: ADDR_WD];
            assign len_arr[gi]   = req_len[gi*ADDR_WD +: ADDR_WD];
            assign burst_arr[gi] = req_burst[gi*2 +: 2];
            assign size_arr[gi]  = req_size[gi*3 +: 3];
        end
    endgenerate

    // Search starts just after the previous winner so every requester gets a turn.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = ID_WD'((int'(last_grant_reg) + off) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        grant      = 1'b0;
        req_ready  = '0;
        case (state_reg)
            IDLE: begin
                if (found && count_reg < CNT_WD'(MAX_OUTSTANDING)) begin
                    grant             = 1'b1;
                    req_ready[winner] = 1'b1;
                    state_next        = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign cmd_valid   = (state_reg == ISSUE);
    assign push        = cmd_valid && cmd_ready;
    // A completion arriving while the FIFO is empty is dropped, even if a push lands this cycle.
    assign pop         = dma_done && (count_reg != '0);
    assign outstanding = count_reg + CNT_WD'(state_reg == ISSUE);

    always_ff @(posedge clk) begin
        if (push) id_mem_reg[wr_ptr_reg] <= cmd_id;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= ID_WD'(NUM_REQ - 1);
            cmd_src_addr   <= '0;
            cmd_dst_addr   <= '0;
            cmd_burst      <= '0;
            cmd_len        <= '0;
            cmd_size       <= '0;
            cmd_id         <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            req_done       <= '0;
            err_done       <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                last_grant_reg <= winner;
                cmd_src_addr   <= src_arr[winner];
                cmd_dst_addr   <= dst_arr[winner];
                cmd_burst      <= burst_arr[winner];
                cmd_len        <= len_arr[winner];
                cmd_size       <= size_arr[winner];
                cmd_id         <= winner;
            end
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_WD'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_WD'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_WD'(1);
                2'b01:   count_reg <= count_reg - CNT_WD'(1);
                default: count_reg <= count_reg;
            endcase
            req_done <= pop ? (NUM_REQ'(1) << id_mem_reg[rd_ptr_reg]) : '0;
            err_done <= dma_done && (count_reg == '0);
        end
    end
endmodule

// File: tb/tb_axi_dma_cmd_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants, commands and completions; a negedge monitor checks them.
module tb_axi_dma_cmd_arbiter;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int MO = 4;

    typedef struct packed {
        logic [1:0]    id;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [AW-1:0] len;
        logic [1:0]    burst;
        logic [2:0]    size;
    } exp_cmd_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR*AW-1:0] req_src_addr = '0, req_dst_addr = '0, req_len = '0;
    logic [NR*2-1:0] req_burst = '0;
    logic [NR*3-1:0] req_size = '0;
    logic [NR-1:0]   req_done;
    logic            cmd_valid;
    logic            cmd_ready = 1'b0;
    logic [AW-1:0]   cmd_src_addr, cmd_dst_addr, cmd_len;
    logic [1:0]      cmd_burst;
    logic [2:0]      cmd_size;
    logic [1:0]      cmd_id;
    logic            dma_done = 1'b0;
    logic [2:0]      outstanding;
    logic            err_done;

    int n_cmp = 0;
    int n_err = 0;

    int             exp_grant [$];
    exp_cmd_t       exp_cmd   [$];
    logic [NR:0]    exp_resp  [$];

    axi_dma_cmd_arbiter #(.NUM_REQ(NR), .ADDR_WD(AW), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src_addr(req_src_addr), .req_dst_addr(req_dst_addr),
        .req_burst(req_burst), .req_len(req_len), .req_size(req_size),
        .req_done(req_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr),
        .cmd_burst(cmd_burst), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .cmd_id(cmd_id), .dma_done(dma_done),
        .outstanding(outstanding), .err_done(err_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented transaction is matched against the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_ready != '0) begin
                if (exp_grant.size() == 0) check("unexpected_grant", 64'(req_ready), 64'd0);
                else begin
                    automatic int e = exp_grant.pop_front();
                    check("grant", 64'(req_ready), 64'(4'(1) << e));
                    $display("grant req_ready=%b", req_ready);
                end
            end
            if (cmd_valid && cmd_ready) begin
                if (exp_cmd.size() == 0) check("unexpected_cmd", 64'(cmd_id), 64'hdead);
                else begin
                    automatic exp_cmd_t c = exp_cmd.pop_front();
                    check("cmd_id", 64'(cmd_id), 64'(c.id));
                    check("cmd_src", 64'(cmd_src_addr), 64'(c.src));
                    check("cmd_dst", 64'(cmd_dst_addr), 64'(c.dst));
                    check("cmd_len", 64'(cmd_len), 64'(c.len));
                    check("cmd_attr", 64'({cmd_burst, cmd_size}), 64'({c.burst, c.size}));
                    $display("cmd id=%0d src=%h dst=%h len=%h", cmd_id, cmd_src_addr, cmd_dst_addr, cmd_len);
                end
            end
            if (req_done != '0 || err_done) begin
                automatic logic [NR:0] act = {err_done, req_done};
                if (exp_resp.size() == 0) check("unexpected_resp", 64'(act), 64'd0);
                else begin
                    check("resp", 64'(act), 64'(exp_resp.pop_front()));
                    $display("resp err=%0b req_done=%b", err_done, req_done);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        dma_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
        exp_cmd.delete();
    endtask

    task automatic drive(input int i, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW-1:0] l, input logic [1:0] b, input logic [2:0] z);
        req_src_addr[i*AW +: AW] = s;
        req_dst_addr[i*AW +: AW] = d;
        req_len[i*AW +: AW]      = l;
        req_burst[i*2 +: 2]      = b;
        req_size[i*3 +: 3]       = z;
    endtask

    task automatic expect_cmd(input int i, input logic [AW-1:0] s, input logic [AW-1:0] d,
                              input logic [AW-1:0] l, input logic [1:0] b, input logic [2:0] z);
        exp_grant.push_back(i);
        exp_cmd.push_back('{2'(i), s, d, l, b, z});
    endtask

    task automatic raise(input int i, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW-1:0] l, input logic [1:0] b, input logic [2:0] z);
        drive(i, s, d, l, b, z);
        expect_cmd(i, s, d, l, b, z);
        req_valid[i] = 1'b1;
    endtask

    // mode: 0 keep valids, 1 drop own valid, 2 drop all valids (applied once the grant is taken)
    task automatic wait_grant(input int i, input int mode);
        bit got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1;
            else step();
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL grant_timeout: got none expected req%0d", i);
        end
        step();
        if (mode == 1) req_valid[i] = 1'b0;
        if (mode == 2) req_valid = '0;
        @(negedge clk);
        check("cmd_valid_lat", 64'(cmd_valid), 64'd1);
        check("cmd_id_lat", 64'(cmd_id), 64'(i));
        step();
    endtask

    task automatic issue(input int i, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW-1:0] l, input logic [1:0] b, input logic [2:0] z);
        raise(i, s, d, l, b, z);
        wait_grant(i, 1);
    endtask

    task automatic pulse_done(input bit is_err, input int id);
        exp_resp.push_back(is_err ? (NR+1)'(1) << NR : (NR+1)'(1) << id);
        dma_done = 1'b1;
    endtask

    task automatic check_out(input string name, input int exp);
        @(negedge clk);
        check(name, 64'(outstanding), 64'(exp));
    endtask

    int rr_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        // Reset state
        step(); step();
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_req_done", 64'(req_done), 64'd0);
        check("rst_err_done", 64'(err_done), 64'd0);
        check("rst_cmd_src", 64'(cmd_src_addr), 64'd0);
        step();
        rst = 1'b0;

        // 1. Single command from requester 2
        cmd_ready = 1'b1;
        issue(2, 32'h1000, 32'h2000, 32'h40, 2'd1, 3'd2);
        pulse_done(0, 2);
        step(); step();
        check_out("single_outstanding", 0);

        // 2. Round-robin with every requester asserting
        do_reset();
        for (int i = 0; i < NR; i++) drive(i, 32'h100 * (i+1), 32'h9000 + i, 32'h10 * i, 2'(i), 3'(i));
        for (int g = 0; g < 5; g++)
            expect_cmd(rr_order[g], 32'h100 * (rr_order[g]+1), 32'h9000 + rr_order[g],
                       32'h10 * rr_order[g], 2'(rr_order[g]), 3'(rr_order[g]));
        req_valid = '1;
        for (int g = 0; g < 5; g++) begin
            wait_grant(rr_order[g], (g == 4) ? 2 : 0);
            pulse_done(0, rr_order[g]);
        end
        step(); step();
        check_out("rr_outstanding", 0);

        // 3. Controller stall: command held, no grants while waiting
        do_reset();
        cmd_ready = 1'b0;
        issue(1, 32'hA5A5_0000, 32'h5A5A_0000, 32'h0, 2'd3, 3'd7);
        raise(3, 32'h3333, 32'h4444, 32'h80, 2'd0, 3'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_cmd_valid", 64'(cmd_valid), 64'd1);
            check("stall_cmd_src", 64'(cmd_src_addr), 64'hA5A5_0000);
            check("stall_req_ready", 64'(req_ready), 64'd0);
            step();
        end
        cmd_ready = 1'b1;
        wait_grant(3, 1);
        pulse_done(0, 1); step();
        pulse_done(0, 3); step(); step();
        check_out("stall_outstanding", 0);

        // 4. Back-pressure at MAX_OUTSTANDING
        do_reset();
        for (int i = 0; i < 4; i++) issue(i, 32'h4000 + i, 32'h5000 + i, 32'h20, 2'd1, 3'd3);
        check_out("full_outstanding", 4);
        step();
        raise(0, 32'h6000, 32'h7000, 32'h30, 2'd2, 3'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("full_no_grant", 64'(req_ready), 64'd0);
            step();
        end
        pulse_done(0, 0);
        wait_grant(0, 1);
        check_out("full_refill", 4);
        step();
        pulse_done(0, 1); step();
        pulse_done(0, 2); step();
        pulse_done(0, 3); step();
        pulse_done(0, 0); step(); step();
        check_out("full_drained", 0);

        // 5. Completion ordering, then a spurious completion
        do_reset();
        issue(1, 32'h11, 32'h12, 32'h13, 2'd1, 3'd1);
        issue(3, 32'h31, 32'h32, 32'h33, 2'd1, 3'd1);
        issue(0, 32'h01, 32'h02, 32'h03, 2'd1, 3'd1);
        pulse_done(0, 1); step();
        pulse_done(0, 3); step();
        pulse_done(0, 0); step();
        pulse_done(1, 0); step(); step();
        check_out("order_outstanding", 0);

        // 6. Reset while a command is being issued with two entries pending
        do_reset();
        issue(0, 32'hC0, 32'hC1, 32'hC2, 2'd1, 3'd2);
        issue(1, 32'hD0, 32'hD1, 32'hD2, 2'd1, 3'd2);
        cmd_ready = 1'b0;
        issue(2, 32'hE0, 32'hE1, 32'hE2, 2'd1, 3'd2);
        check_out("pre_rst_outstanding", 3);
        step();
        do_reset();
        @(negedge clk);
        check("post_rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("post_rst_outstanding", 64'(outstanding), 64'd0);
        step();
        cmd_ready = 1'b1;
        pulse_done(1, 0); step(); step(); step();

        check("left_grants", 64'(exp_grant.size()), 64'd0);
        check("left_cmds", 64'(exp_cmd.size()), 64'd0);
        check("left_resps", 64'(exp_resp.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
